// File: rtl/wrin_pkg.sv
// wrin_pkg: shared types and sizing helpers for the wrin_param input wrapper.
//   coll_state_e   - states of the bus-word collection FSM (wrin_collector)
//   launch_state_e - states of the accelerator launch FSM (wrin_param)
//   calc_n         - words per frame
//   calc_idx_w     - width of the word index counter (never below 1)
// Optional feature macro used by the importing files: WRIN_DBL_BUF_EN.
package wrin_pkg;

  typedef enum logic [2:0] {
    C_IDLE,
    C_LOAD,
    C_ACK,
    C_DRW,
    C_FULL
  } coll_state_e;

  typedef enum logic [1:0] {
    L_IDLE,
    L_WAIT,
    L_START,
    L_CALC
  } launch_state_e;

  function automatic int calc_n(input int x_words, input int y_words);
    return x_words + y_words;
  endfunction

  function automatic int calc_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Sizes for the default 8-bit, 2+1-word configuration.
  localparam int DEF_N     = calc_n(2, 1);
  localparam int DEF_IDX_W = calc_idx_w(DEF_N);

endpackage

// File: rtl/wrin_collector.sv
// wrin_collector: collects one frame of N = X_WORDS+Y_WORDS bus words via the
// drdy/dac four-phase handshake and places word i at stage[i*BUS_W +: BUS_W]
// (little-endian, x words first, then y words).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus, drdy    host data word and data-ready level
//   launch_idle  launch FSM is in its idle state
//   dac          data-accepted acknowledge (registered)
//   load_go      frame hand-over strobe to the launch side
//   stage        assembled frame contents
//   idx          current word index
//   coll_busy    collection FSM not idle
// WRIN_DBL_BUF_EN: when defined, collection runs independently of the launch
// FSM and parks in C_FULL until the launch side can take the frame.
module wrin_collector
  import wrin_pkg::*;
#(
  parameter int BUS_W   = 8,
  parameter int X_WORDS = 2,
  parameter int Y_WORDS = 1,
  parameter int N       = calc_n(X_WORDS, Y_WORDS),
  parameter int IDX_W   = calc_idx_w(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_W-1:0]     bus,
  input  logic                 drdy,
  input  logic                 launch_idle,
  output logic                 dac,
  output logic                 load_go,
  output logic [N*BUS_W-1:0]   stage,
  output logic [IDX_W-1:0]     idx,
  output logic                 coll_busy
);

  coll_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N*BUS_W-1:0]   stage_q, stage_d;
  logic                 dac_q, dac_d;
  logic                 last_word;
  logic                 frame_done;

  assign last_word  = (idx_q == IDX_W'(N - 1));
  // Host has released drdy after the final word's acknowledge.
  assign frame_done = (state_q == C_ACK) && !drdy && last_word;

`ifdef WRIN_DBL_BUF_EN
  assign load_go = (frame_done || (state_q == C_FULL)) && launch_idle;
`else
  // Collection only ever runs while the launch FSM is idle.
  assign load_go = frame_done;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    case (state_q)
      C_IDLE: begin
`ifdef WRIN_DBL_BUF_EN
        idx_d = '0;
        if (drdy) state_d = C_LOAD;
`else
        // While the launch side owns the operands this idle state stands in
        // for WAIT/START/CALC: idx keeps its final value and drdy is ignored.
        if (launch_idle) begin
          idx_d = '0;
          if (drdy) state_d = C_LOAD;
        end
`endif
      end
      C_LOAD: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) stage_d[i*BUS_W +: BUS_W] = bus;
        end
        state_d = C_ACK;
      end
      C_ACK: begin
        if (!drdy) begin
          if (last_word) begin
`ifdef WRIN_DBL_BUF_EN
            if (launch_idle) begin
              state_d = C_IDLE;
              idx_d   = '0;
            end else begin
              state_d = C_FULL;
            end
`else
            state_d = C_IDLE;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = C_DRW;
          end
        end
      end
      C_DRW: begin
        if (drdy) state_d = C_LOAD;
      end
      C_FULL: begin
        if (launch_idle) begin
          state_d = C_IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = C_IDLE;
    endcase
    dac_d = (state_d == C_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
      idx_q   <= '0;
      stage_q <= '0;
      dac_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      dac_q   <= dac_d;
    end
  end

  assign dac       = dac_q;
  assign stage     = stage_q;
  assign idx       = idx_q;
  assign coll_busy = (state_q != C_IDLE);

endmodule

// File: rtl/wrin_param.sv
// wrin_param: parametrised host-bus input wrapper for the accelerator core.
// Collects X_WORDS+Y_WORDS words of BUS_W bits, presents them as operands
// x/y, then launches the core with a start/ready handshake and keeps x/y
// stable until the computation completes.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus, drdy, dac  host word, data-ready, data-accepted
//   obe, ready      accelerator output-buffer-empty, ready/done
//   start           accelerator start (registered)
//   x, y            operands
//   busy            any FSM outside its idle state
// WRIN_DBL_BUF_EN: when defined, x/y are separate registers loaded from the
// collector's staging buffer, so a new frame can be collected during a
// computation.
module wrin_param
  import wrin_pkg::*;
#(
  parameter int BUS_W   = 8,
  parameter int X_WORDS = 2,
  parameter int Y_WORDS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BUS_W-1:0]           bus,
  input  logic                       drdy,
  output logic                       dac,
  input  logic                       obe,
  input  logic                       ready,
  output logic                       start,
  output logic [X_WORDS*BUS_W-1:0]   x,
  output logic [Y_WORDS*BUS_W-1:0]   y,
  output logic                       busy
);

  localparam int N     = calc_n(X_WORDS, Y_WORDS);
  localparam int IDX_W = calc_idx_w(N);
  localparam int XW    = X_WORDS * BUS_W;

  launch_state_e        lst_q, lst_d;
  logic                 start_q, start_d;
  logic                 launch_idle;
  logic                 load_go;
  logic                 coll_busy;
  logic [N*BUS_W-1:0]   stage;
  logic [IDX_W-1:0]     idx;

  assign launch_idle = (lst_q == L_IDLE);

  wrin_collector #(
    .BUS_W   (BUS_W),
    .X_WORDS (X_WORDS),
    .Y_WORDS (Y_WORDS),
    .N       (N),
    .IDX_W   (IDX_W)
  ) u_coll (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .drdy        (drdy),
    .launch_idle (launch_idle),
    .dac         (dac),
    .load_go     (load_go),
    .stage       (stage),
    .idx         (idx),
    .coll_busy   (coll_busy)
  );

  always_comb begin
    lst_d = lst_q;
    case (lst_q)
      L_IDLE:  if (load_go)       lst_d = L_WAIT;
      L_WAIT:  if (ready && obe)  lst_d = L_START;
      // start is held for as long as ready stays high, even if ready was
      // already high on entry.
      L_START: if (!ready)        lst_d = L_CALC;
      L_CALC:  if (ready)         lst_d = L_IDLE;
      default:                    lst_d = L_IDLE;
    endcase
    start_d = (lst_d == L_START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lst_q   <= L_IDLE;
      start_q <= 1'b0;
    end else begin
      lst_q   <= lst_d;
      start_q <= start_d;
    end
  end

  assign start = start_q;
  assign busy  = coll_busy || !launch_idle;

`ifdef WRIN_DBL_BUF_EN
  logic [XW-1:0]            x_q, x_d;
  logic [N*BUS_W-XW-1:0]    y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_go) begin
      x_d = stage[XW-1:0];
      y_d = stage[N*BUS_W-1:XW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;
`else
  // Single buffer: words land directly in the operand bits.
  assign x = stage[XW-1:0];
  assign y = stage[N*BUS_W-1:XW];
`endif

  // idx is only observed for debug; keep it from being flagged as unused.
  logic idx_unused;
  assign idx_unused = ^idx;

endmodule

// File: tb/tb_wrin_param.sv
module tb_wrin_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // default instance: BUS_W=8, X_WORDS=2, Y_WORDS=1
  logic [7:0]  bus;
  logic        drdy, ready, obe;
  logic        dac, start, busy;
  logic [15:0] x;
  logic [7:0]  y;
  // second instance: BUS_W=4, X_WORDS=3, Y_WORDS=2
  logic [3:0]  bus1;
  logic        drdy1, ready1, obe1;
  logic        dac1, start1, busy1;
  logic [11:0] x1;
  logic [7:0]  y1;

  wrin_param dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .drdy(drdy), .dac(dac),
    .obe(obe), .ready(ready), .start(start), .x(x), .y(y), .busy(busy)
  );

  wrin_param #(.BUS_W(4), .X_WORDS(3), .Y_WORDS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .drdy(drdy1), .dac(dac1),
    .obe(obe1), .ready(ready1), .start(start1), .x(x1), .y(y1), .busy(busy1)
  );

  int checks = 0;
  int failures = 0;

  // Operand model: what x/y must hold according to the frames sent.
  logic [15:0] exp_x = '0;
  logic [7:0]  exp_y = '0;
  bit          chk_xy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Word i of a frame lands at bit i*8; words 0..1 form x, word 2 forms y.
  task automatic model_frame(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
    logic [7:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    exp_x = '0;
    exp_y = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) exp_x = exp_x | (16'(w[i]) << (8 * i));
      else       exp_y = exp_y | (8'(w[i]) << (8 * (i - 2)));
    end
  endtask

  always @(negedge clk) begin
    if (chk_xy) begin
      chk("model_x", 32'(x), 32'(exp_x));
      chk("model_y", 32'(y), 32'(exp_y));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dac(input logic v, input string nm);
    int n = 0;
    while (dac !== v && n < 20) begin
      step();
      n++;
    end
    chk(nm, 32'(dac), 32'(v));
  endtask

  task automatic send_word(input logic [7:0] w, input int hold);
    bus  = w;
    drdy = 1'b1;
    wait_dac(1'b1, "dac_rise");
    for (int i = 0; i < hold; i++) begin
      step();
      chk("dac_held", 32'(dac), 32'd1);
    end
    drdy = 1'b0;
    wait_dac(1'b0, "dac_fall");
  endtask

  task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int hold0, input bit upd);
`ifndef WRIN_DBL_BUF_EN
    chk_xy = 1'b0;
`endif
    send_word(w0, hold0);
    send_word(w1, 0);
    send_word(w2, 0);
    if (upd) begin
      model_frame(w0, w1, w2);
      chk_xy = 1'b1;
    end
  endtask

  task automatic send_word1(input logic [3:0] w);
    int n;
    bus1  = w;
    drdy1 = 1'b1;
    n = 0;
    while (dac1 !== 1'b1 && n < 20) begin step(); n++; end
    chk("dac1_rise", 32'(dac1), 32'd1);
    drdy1 = 1'b0;
    n = 0;
    while (dac1 !== 1'b0 && n < 20) begin step(); n++; end
    chk("dac1_fall", 32'(dac1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus = '0; drdy = 1'b0; ready = 1'b0; obe = 1'b0;
    bus1 = '0; drdy1 = 1'b0; ready1 = 1'b0; obe1 = 1'b0;
    repeat (3) step();
    chk("rst_x", 32'(x), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_dac", 32'(dac), 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    chk_xy = 1'b1;
    step();

    // Basic frame 34,12,56 with core ready and output empty
    ready = 1'b1; obe = 1'b1;
    send_frame(8'h34, 8'h12, 8'h56, 0, 1'b1);
    chk("frame1_x", 32'(x), 32'h1234);
    chk("frame1_y", 32'(y), 32'h56);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_start", 32'(start), 32'd0);
    step();
    chk("start_rise", 32'(start), 32'd1);
    ready = 1'b0;
    step();
    chk("start_fall", 32'(start), 32'd0);
    chk("calc_busy", 32'(busy), 32'd1);
    ready = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    $display("txn frame1 x=%h y=%h", x, y);

    // drdy held 5 cycles on the first word; output buffer not empty
    obe = 1'b0;
    send_frame(8'hAA, 8'hBB, 8'hCC, 5, 1'b1);
    chk("hold_x", 32'(x), 32'hBBAA);
    chk("hold_y", 32'(y), 32'hCC);
`ifndef WRIN_DBL_BUF_EN
    bus = 8'hFF; drdy = 1'b1;
`endif
    for (int i = 0; i < 10; i++) begin
      step();
      chk("obe0_no_start", 32'(start), 32'd0);
`ifndef WRIN_DBL_BUF_EN
      chk("wait_drdy_ignored", 32'(dac), 32'd0);
`endif
    end
    drdy = 1'b0;
    obe = 1'b1;
    step();
    chk("obe1_start", 32'(start), 32'd1);
    ready = 1'b0;
    step();
    chk("calc_start_low", 32'(start), 32'd0);
    ready = 1'b1;
    step();
    chk("calc_exit_busy", 32'(busy), 32'd0);
    $display("txn held-frame x=%h y=%h", x, y);

    // Reset after 2 of 3 words
`ifndef WRIN_DBL_BUF_EN
    chk_xy = 1'b0;
`endif
    send_word(8'h11, 0);
    send_word(8'h22, 0);
`ifndef WRIN_DBL_BUF_EN
    chk("partial_x", 32'(x), 32'h2211);
`endif
    step();
    #1 rst_n = 1'b0;
    exp_x = '0; exp_y = '0; chk_xy = 1'b1;
    #1;
    chk("arst_x", 32'(x), 32'h0);
    chk("arst_y", 32'(y), 32'h0);
    chk("arst_dac", 32'(dac), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_start", 32'(start), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    send_frame(8'h78, 8'h9A, 8'hBC, 0, 1'b1);
    chk("postrst_x", 32'(x), 32'h9A78);
    chk("postrst_y", 32'(y), 32'hBC);
    step();
    chk("postrst_start", 32'(start), 32'd1);
    ready = 1'b0;
    step();
    ready = 1'b1;
    step();
    chk("postrst_idle", 32'(busy), 32'd0);
    $display("txn post-reset x=%h y=%h", x, y);

    // 4-bit bus, 3+2 words A..E
    send_word1(4'hA);
    send_word1(4'hB);
    send_word1(4'hC);
    send_word1(4'hD);
    send_word1(4'hE);
    chk("p2_x", 32'(x1), 32'hCBA);
    chk("p2_y", 32'(y1), 32'hED);
    chk("p2_busy", 32'(busy1), 32'd1);
    chk("p2_no_start", 32'(start1), 32'd0);
`ifndef WRIN_DBL_BUF_EN
    chk("p2_idx_final", 32'(dut1.u_coll.idx_q), 32'd4);
`endif
    $display("txn p2 x=%h y=%h", x1, y1);

`ifdef WRIN_DBL_BUF_EN
    // Second frame during CALC, third frame blocked while staging is full
    send_frame(8'h01, 8'h02, 8'h03, 0, 1'b1);
    step();
    chk("dbl_start", 32'(start), 32'd1);
    ready = 1'b0;
    step();
    send_frame(8'h04, 8'h05, 8'h06, 0, 1'b0);
    chk("dbl_hold_x", 32'(x), 32'h0201);
    chk("dbl_full_busy", 32'(busy), 32'd1);
    bus = 8'h07; drdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("dbl_full_dac", 32'(dac), 32'd0);
    end
    drdy = 1'b0;
    ready = 1'b1;
    step();
    chk("dbl_exit_x", 32'(x), 32'h0201);
    step();
    chk("dbl_copy_x", 32'(x), 32'h0504);
    chk("dbl_copy_y", 32'(y), 32'h06);
    model_frame(8'h04, 8'h05, 8'h06);
    step();
    chk("dbl_start2", 32'(start), 32'd1);
    ready = 1'b0;
    step();
    ready = 1'b1;
    step();
    chk("dbl_idle", 32'(busy), 32'd0);
    $display("txn dbl x=%h y=%h", x, y);
`endif

    chk_xy = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
